// File: rtl/pu_output_packer_pkg.sv
// Shared sizing and FSM encodings for the PU output packer.
package pu_output_packer_pkg;

  localparam int OP_WIDTH   = 16;
  localparam int NUM_PE     = 8;
  localparam int DATA_WIDTH = NUM_PE * OP_WIDTH;
  localparam int AXI_DATA_W = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int COUNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pk_state_e;

  // Beats needed to move one row through the narrower memory port.
  function automatic int beats_per_row(input int data_w, input int axi_w);
    return data_w / axi_w;
  endfunction

  // Index width that stays legal when a row is a single beat.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_out_fifo.sv
// Register-based row FIFO with show-ahead head and registered occupancy.
module pu_out_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 128,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pu_output_packer.sv
// Buffers PE-row results and serializes them into memory write beats per layer.
module pu_output_packer
  import pu_output_packer_pkg::*;
#(
  parameter  int OP_W    = OP_WIDTH,
  parameter  int N_PE    = NUM_PE,
  parameter  int AXI_W   = AXI_DATA_W,
  parameter  int DEPTH   = FIFO_DEPTH,
  parameter  int CNT_ROW = COUNT_W,
  localparam int DW      = OP_W * N_PE,
  localparam int BEATS   = beats_per_row(DW, AXI_W),
  localparam int BIDX_W  = idx_width(BEATS),
  localparam int FCNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      pu_write_data,
  input  logic               pu_write_req,
  output logic               pu_write_ready,
  input  logic               layer_start,
  input  logic [CNT_ROW-1:0] layer_rows,
  output logic [AXI_W-1:0]   mem_wr_data,
  output logic               mem_wr_valid,
  input  logic               mem_wr_ready,
  output logic               mem_wr_last,
  output logic               layer_done,
  output logic [FCNT_W-1:0]  fifo_count,
  output logic               overflow_err
);

  pk_state_e                      state_q, state_d;
  logic [CNT_ROW-1:0]             rows_left_q, rows_left_d;
  logic [BIDX_W-1:0]              beat_idx_q, beat_idx_d;
  logic                           overflow_q;
  logic                           fifo_full, fifo_empty, pop;
  logic                           beat_acc, last_beat;
  logic [DW-1:0]                  head;
  logic [BEATS-1:0][AXI_W-1:0]    head_beats;

  pu_out_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pu_write_req),
    .pop_i   (pop),
    .wdata_i (pu_write_data),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pu_write_ready = !fifo_full;
  assign overflow_err   = overflow_q;

  // Low slice of the row goes out first.
  assign head_beats   = head;
  assign last_beat    = (beat_idx_q == BIDX_W'(BEATS - 1));
  assign mem_wr_valid = (state_q == ST_RUN) && !fifo_empty;
  assign mem_wr_data  = mem_wr_valid ? head_beats[beat_idx_q] : '0;
  assign mem_wr_last  = mem_wr_valid && (rows_left_q == CNT_ROW'(1)) && last_beat;
  assign layer_done   = (state_q == ST_DONE);
  assign beat_acc     = mem_wr_valid && mem_wr_ready;

  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    beat_idx_d  = beat_idx_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          rows_left_d = layer_rows;
          beat_idx_d  = '0;
          state_d     = (layer_rows == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat_acc) begin
          if (last_beat) begin
            beat_idx_d  = '0;
            pop         = 1'b1;
            rows_left_d = rows_left_q - CNT_ROW'(1);
            if (rows_left_q == CNT_ROW'(1)) state_d = ST_DONE;
          end else begin
            beat_idx_d = beat_idx_q + BIDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rows_left_q <= '0;
      beat_idx_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      beat_idx_q  <= beat_idx_d;
      // A request against a full FIFO is dropped; remember that it happened.
      if (pu_write_req && fifo_full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pu_output_packer.sv
// Directed bench for pu_output_packer with hand-derived expected beats.
module tb_pu_output_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] pu_write_data = '0;
  logic         pu_write_req = 1'b0;
  logic         pu_write_ready;
  logic         layer_start = 1'b0;
  logic [15:0]  layer_rows = '0;
  logic [63:0]  mem_wr_data;
  logic         mem_wr_valid;
  logic         mem_wr_ready = 1'b0;
  logic         mem_wr_last;
  logic         layer_done;
  logic [3:0]   fifo_count;
  logic         overflow_err;

  int total = 0;
  int fails = 0;

  pu_output_packer dut (
    .clk            (clk),
    .reset          (reset),
    .pu_write_data  (pu_write_data),
    .pu_write_req   (pu_write_req),
    .pu_write_ready (pu_write_ready),
    .layer_start    (layer_start),
    .layer_rows     (layer_rows),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_last    (mem_wr_last),
    .layer_done     (layer_done),
    .fifo_count     (fifo_count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkrow(input int k);
    logic [31:0] b;
    b = 32'hC0DE_0000 + 32'(k * 4);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic push(input logic [127:0] row);
    pu_write_data = row;
    pu_write_req  = 1'b1;
    tick();
    pu_write_req  = 1'b0;
  endtask

  task automatic start(input int rows);
    layer_rows  = 16'(rows);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  // Waits for one beat to be accepted; data/last are checked every valid cycle, stalls included.
  task automatic beat(input logic [63:0] d, input logic l, input string tag, input bit rnd);
    bit acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      mem_wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_wr_valid) begin
        chk({tag, " data"}, 128'(mem_wr_data), 128'(d));
        chk({tag, " last"}, 128'(mem_wr_last), 128'(l));
        if (mem_wr_ready) acc = 1'b1;
      end
      tick();
    end
    chk({tag, " accepted"}, 128'(acc), 128'(1'b1));
  endtask

  task automatic drain(input int first, input int n, input bit rnd);
    logic [127:0] r;
    for (int i = 0; i < n; i++) begin
      r = mkrow(first + i);
      for (int h = 0; h < 2; h++)
        beat(r[h*64 +: 64], (i == n - 1) && (h == 1), $sformatf("row%0d.b%0d", first + i, h), rnd);
    end
    mem_wr_ready = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    chk({tag, " done pulse"}, 128'(layer_done), 128'(1'b1));
    chk({tag, " valid in done"}, 128'(mem_wr_valid), 128'(1'b0));
    tick();
    chk({tag, " done cleared"}, 128'(layer_done), 128'(1'b0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"}, 128'(pu_write_ready), 128'(1'b1));
    chk({tag, " valid"}, 128'(mem_wr_valid), 128'(1'b0));
    chk({tag, " data"}, 128'(mem_wr_data), 128'(0));
    chk({tag, " last"}, 128'(mem_wr_last), 128'(1'b0));
    chk({tag, " done"}, 128'(layer_done), 128'(1'b0));
    chk({tag, " count"}, 128'(fifo_count), 128'(0));
    chk({tag, " ovf"}, 128'(overflow_err), 128'(1'b0));
  endtask

  initial begin
    logic [127:0] r0, r1, r;

    tick();
    tick();
    chk_reset("reset");
    reset = 1'b0;
    tick();

    // Two-row layer, low slice first, last on the fourth beat.
    r0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    r1 = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
    start(2);
    push(r0);
    chk("t1 valid after push", 128'(mem_wr_valid), 128'(1'b1));
    push(r1);
    chk("t1 count", 128'(fifo_count), 128'(2));
    beat(r0[63:0],   1'b0, "t1 b0", 1'b0);
    beat(r0[127:64], 1'b0, "t1 b1", 1'b0);
    beat(r1[63:0],   1'b0, "t1 b2", 1'b0);
    beat(r1[127:64], 1'b1, "t1 b3", 1'b0);
    mem_wr_ready = 1'b0;
    chk_done("t1");

    // Fill to full with memory stalled, then overflow.
    start(8);
    for (int i = 0; i < 8; i++) push(mkrow(i));
    chk("t2 count full", 128'(fifo_count), 128'(8));
    chk("t2 ready low", 128'(pu_write_ready), 128'(1'b0));
    push(128'hDEAD_BEEF);
    chk("t2 ovf", 128'(overflow_err), 128'(1'b1));
    chk("t2 count held", 128'(fifo_count), 128'(8));
    drain(0, 8, 1'b0);
    chk_done("t2");
    chk("t2 empty", 128'(fifo_count), 128'(0));

    // Random backpressure over five rows.
    start(5);
    for (int i = 0; i < 5; i++) push(mkrow(10 + i));
    drain(10, 5, 1'b1);
    chk_done("t3");

    // Full FIFO: a push beside a pop is refused and nothing is corrupted.
    start(8);
    for (int i = 0; i < 8; i++) push(mkrow(20 + i));
    r = mkrow(20);
    beat(r[63:0], 1'b0, "t4 row20.b0", 1'b0);
    pu_write_data = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    pu_write_req  = 1'b1;
    mem_wr_ready  = 1'b1;
    chk("t4 ready low", 128'(pu_write_ready), 128'(1'b0));
    chk("t4 row20.b1", 128'(mem_wr_data), 128'(r[127:64]));
    tick();
    pu_write_req = 1'b0;
    mem_wr_ready = 1'b0;
    chk("t4 count 7", 128'(fifo_count), 128'(7));
    drain(21, 7, 1'b0);
    chk_done("t4");
    chk("t4 empty", 128'(fifo_count), 128'(0));

    // Zero-row layer, then a restart attempt while running.
    start(0);
    chk_done("t5 zero");
    chk("t5 valid idle", 128'(mem_wr_valid), 128'(1'b0));
    start(2);
    push(mkrow(40));
    start(5);
    push(mkrow(41));
    drain(40, 2, 1'b0);
    chk_done("t5");

    // Reset after the first of two beats.
    start(2);
    push(mkrow(50));
    r = mkrow(50);
    beat(r[63:0], 1'b0, "t6 b0", 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("t6 midreset");
    tick();
    reset = 1'b0;
    mem_wr_ready = 1'b0;
    tick();
    start(1);
    push(mkrow(60));
    drain(60, 1, 1'b0);
    chk_done("t6");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
